wb_interconnect_n: RTL
======================

# wb_interconnect_n

Parametrised single-master Wishbone (pipelined) interconnect that routes the picorv32 wrapper's bus to `NSLAVES` targets. Targets are selected through a base/mask address map. The block enforces one outstanding transaction at a time. It returns a bus error for unmapped addresses, slave error responses, and slave timeouts, and captures the faulting address. It replaces the fixed-map interconnect between the core wrapper and the LED/GPIO/UART/timer/SRAM peripherals.

## Interface
- `NSLAVES`, 4: number of slave ports (1..16).
- `AW`, 32: address width.
- `DW`, 32: data width; `DW/8` byte selects.
- `SLAVE_BASE`, {NSLAVES{32'h0}}: packed `NSLAVES*AW`; base of slave k is at bits [k*AW +: AW].
- `SLAVE_MASK`, {NSLAVES{32'h0}}: packed `NSLAVES*AW`; slave k matches when `(addr & mask_k) == base_k`.
- `TIMEOUT`, 255: cycles to wait for a slave ack/err before erroring (1..65535).

Ports (the clock is `i_clk`; reset is `i_resetn`, synchronous and active-low):
- `i_clk` in 1: clock.
- `i_resetn` in 1: synchronous active-low reset.
- `i_wb_cyc`, `i_wb_stb`, `i_wb_we` in 1: master cycle, strobe, write enable.
- `i_wb_addr` in AW; `i_wb_data` in DW; `i_wb_sel` in DW/8: master request.
- `o_wb_ack`, `o_wb_err` out 1: master response pulses.
- `o_wb_stall` out 1: master stall.
- `o_wb_data` out DW: read data, valid with `o_wb_ack`.
- `o_wb_err_address` out AW: address of the most recent errored transaction.
- `o_s_cyc`, `o_s_stb` out NSLAVES: per-slave cycle and strobe; one-hot or zero.
- `o_s_we` out 1; `o_s_addr` out AW; `o_s_data` out DW; `o_s_sel` out DW/8: shared, registered request.
- `i_s_ack`, `i_s_err`, `i_s_stall` in NSLAVES: per-slave responses.
- `i_s_data` in NSLAVES*DW: packed read data; slave k is at [k*DW +: DW].

## Operation
- States: IDLE, REQ, WAIT, RESP.
- **IDLE**
  - `o_wb_stall=0`.
  - On `i_wb_cyc & i_wb_stb`: register addr/data/sel/we and decode.
  - If several slaves match, the lowest index wins.
  - Match: latch index, go to REQ.
  - No match: go to RESP with error; the error source is "unmapped".
- **REQ**
  - Drive `o_s_cyc[k]` and `o_s_stb[k]`.
  - When `!i_s_stall[k]`, go to WAIT; `o_s_stb` drops and `o_s_cyc` stays high.
  - An `i_s_ack`/`i_s_err` seen in the same cycle as acceptance goes straight to RESP.
- **WAIT**
  - Hold `o_s_cyc[k]`.
  - `i_s_ack[k]`: capture `i_s_data[k]`, go to RESP with ack.
  - `i_s_err[k]`: go to RESP with error.
- **Timeout**
  - A 16-bit counter clears on entry to REQ and increments in REQ/WAIT.
  - When the counter reaches `TIMEOUT - 1` with no response, drop the slave cyc/stb and go to RESP with error.
- **RESP**
  - Pulse `o_wb_ack` or `o_wb_err` for exactly one cycle; all `o_s_cyc` are 0.
  - Return to IDLE.
  - On error, load `o_wb_err_address` with the registered address. It holds until the next error.
- **Abort**
  - `i_wb_cyc=0` in REQ/WAIT: drop the slave cyc/stb on the next edge and go to IDLE.
  - No ack or err is issued; the `o_wb_err_address` register is unchanged.
- `o_wb_stall=1` in REQ, WAIT and RESP.
- Responses from unselected slaves are ignored.
- Ack and err together from the selected slave: err wins.

## Timing
- All outputs are registered.
- Reset values: state IDLE; all `o_s_cyc`/`o_s_stb` 0; `o_wb_ack`, `o_wb_err` and `o_wb_stall` 0; `o_wb_data` 0; `o_wb_err_address` 0; shared `o_s_*` 0.
- Mapped access, slave with no stall that acks on its stb cycle:
  - Accept at edge 0.
  - Slave stb during cycle 1.
  - `o_wb_ack` during cycle 2.
  - Latency is 2 cycles; each slave stall or wait cycle adds 1.
- Unmapped access: `o_wb_err` during cycle 1.
- Timeout: `o_wb_err` exactly `TIMEOUT+1` cycles after acceptance.
- Reset asserted mid-transaction: on the next edge all outputs take their reset values; no response is issued.

## Test plan
- **Mapped read, slave 1.** NSLAVES=4; base1=0x0200_0000, mask 0xFF00_0000. Read 0x0200_0010; slave1 returns 0xDEADBEEF with no stall. Expect `o_s_stb[1]` in cycle 1 and `o_wb_ack` with 0xDEADBEEF in cycle 2; no other `o_s_cyc` asserted.
- **Stalled write.** Write 0x12345678, sel 4'b0011, to slave 2; `i_s_stall` is held for 3 cycles. Expect stb held for 4 cycles, `o_s_data`/`o_s_sel` stable throughout, ack in cycle 5, `o_wb_stall=1` throughout.
- **Unmapped address.** Access 0xF000_0000 with no match. Expect `o_wb_err` in cycle 1, `o_wb_err_address=0xF000_0000`, and no `o_s_cyc` asserted.
- **Timeout.** TIMEOUT=8; the slave never responds. Expect `o_wb_err` at cycle 9, slave cyc dropped, and the next access serviced normally.
- **Overlap, error, abort.**
  - Slaves 0 and 3 both match: slave 0 is selected.
  - Slave returns `i_s_err` together with ack: expect err.
  - Master drops `i_wb_cyc` in WAIT: slave cyc falls on the next edge, with no ack or err.
- **Reset mid-transaction.** Pull `i_resetn` low during WAIT. Expect all outputs 0 on the next edge and the state back in IDLE.

Source files
------------

// File: rtl/wb_interconnect_n.sv
// Single-master pipelined Wishbone interconnect: base/mask decode to NSLAVES targets,
// one outstanding transaction, bus error on unmapped address, slave error or timeout.
module wb_interconnect_n #(
   parameter int unsigned                NSLAVES    = 4,
   parameter int unsigned                AW         = 32,
   parameter int unsigned                DW         = 32,
   parameter logic [NSLAVES*AW-1:0]      SLAVE_BASE = '0,
   parameter logic [NSLAVES*AW-1:0]      SLAVE_MASK = '0,
   parameter int unsigned                TIMEOUT    = 255
) (
   input  logic                    i_clk,
   input  logic                    i_resetn,
   input  logic                    i_wb_cyc,
   input  logic                    i_wb_stb,
   input  logic                    i_wb_we,
   input  logic [AW-1:0]           i_wb_addr,
   input  logic [DW-1:0]           i_wb_data,
   input  logic [DW/8-1:0]         i_wb_sel,
   output logic                    o_wb_ack,
   output logic                    o_wb_err,
   output logic                    o_wb_stall,
   output logic [DW-1:0]           o_wb_data,
   output logic [AW-1:0]           o_wb_err_address,
   output logic [NSLAVES-1:0]      o_s_cyc,
   output logic [NSLAVES-1:0]      o_s_stb,
   output logic                    o_s_we,
   output logic [AW-1:0]           o_s_addr,
   output logic [DW-1:0]           o_s_data,
   output logic [DW/8-1:0]         o_s_sel,
   input  logic [NSLAVES-1:0]      i_s_ack,
   input  logic [NSLAVES-1:0]      i_s_err,
   input  logic [NSLAVES-1:0]      i_s_stall,
   input  logic [NSLAVES*DW-1:0]   i_s_data
);

   localparam int unsigned IW = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

   state_t              state, state_d;
   logic [IW-1:0]       idx, idx_d;
   logic [15:0]         cnt, cnt_d;
   logic                hit;
   logic [IW-1:0]       hit_idx;
   logic [NSLAVES-1:0]  hit_onehot;
   logic                sel_ack, sel_err, sel_stall;
   logic [DW-1:0]       sel_data;
   logic [NSLAVES-1:0]  cyc_d, stb_d;
   logic                ack_d, err_d, stall_d;
   logic                load_req, load_rdata, err_from_in, err_from_req;
   logic                timed_out;

   // Lowest matching index wins: later matches are ignored once hit is set.
   always_comb begin
      hit        = 1'b0;
      hit_idx    = '0;
      hit_onehot = '0;
      for (int unsigned i = 0; i < NSLAVES; i++) begin
         if (!hit && ((i_wb_addr & SLAVE_MASK[i*AW +: AW]) == SLAVE_BASE[i*AW +: AW])) begin
            hit           = 1'b1;
            hit_idx       = IW'(i);
            hit_onehot[i] = 1'b1;
         end
      end
   end

   always_comb begin
      sel_ack   = 1'b0;
      sel_err   = 1'b0;
      sel_stall = 1'b0;
      sel_data  = '0;
      for (int unsigned i = 0; i < NSLAVES; i++) begin
         if (idx == IW'(i)) begin
            sel_ack   = i_s_ack[i];
            sel_err   = i_s_err[i];
            sel_stall = i_s_stall[i];
            sel_data  = i_s_data[i*DW +: DW];
         end
      end
   end

   assign timed_out = (cnt == 16'(TIMEOUT - 1));

   always_comb begin
      state_d      = state;
      idx_d        = idx;
      cnt_d        = cnt;
      cyc_d        = o_s_cyc;
      stb_d        = o_s_stb;
      ack_d        = 1'b0;
      err_d        = 1'b0;
      load_req     = 1'b0;
      load_rdata   = 1'b0;
      err_from_in  = 1'b0;
      err_from_req = 1'b0;
      case (state)
         IDLE: begin
            if (i_wb_cyc && i_wb_stb) begin
               load_req = 1'b1;
               if (hit) begin
                  idx_d   = hit_idx;
                  cyc_d   = hit_onehot;
                  stb_d   = hit_onehot;
                  cnt_d   = '0;
                  state_d = REQ;
               end else begin
                  err_d       = 1'b1;
                  err_from_in = 1'b1;
                  state_d     = RESP;
               end
            end
         end
         REQ, WAIT: begin
            // Priority: master abort, then slave response (err over ack), then timeout.
            if (!i_wb_cyc) begin
               cyc_d   = '0;
               stb_d   = '0;
               state_d = IDLE;
            end else if ((state == WAIT || !sel_stall) && (sel_err || sel_ack)) begin
               cyc_d   = '0;
               stb_d   = '0;
               state_d = RESP;
               if (sel_err) begin
                  err_d        = 1'b1;
                  err_from_req = 1'b1;
               end else begin
                  ack_d      = 1'b1;
                  load_rdata = 1'b1;
               end
            end else if (timed_out) begin
               cyc_d        = '0;
               stb_d        = '0;
               err_d        = 1'b1;
               err_from_req = 1'b1;
               state_d      = RESP;
            end else begin
               cnt_d = cnt + 16'd1;
               if (state == REQ && !sel_stall) begin
                  stb_d   = '0;
                  state_d = WAIT;
               end
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      stall_d = (state_d != IDLE);
   end

   always_ff @(posedge i_clk) begin
      if (!i_resetn) begin
         state            <= IDLE;
         idx              <= '0;
         cnt              <= '0;
         o_s_cyc          <= '0;
         o_s_stb          <= '0;
         o_wb_ack         <= 1'b0;
         o_wb_err         <= 1'b0;
         o_wb_stall       <= 1'b0;
         o_wb_data        <= '0;
         o_wb_err_address <= '0;
         o_s_we           <= 1'b0;
         o_s_addr         <= '0;
         o_s_data         <= '0;
         o_s_sel          <= '0;
      end else begin
         state      <= state_d;
         idx        <= idx_d;
         cnt        <= cnt_d;
         o_s_cyc    <= cyc_d;
         o_s_stb    <= stb_d;
         o_wb_ack   <= ack_d;
         o_wb_err   <= err_d;
         o_wb_stall <= stall_d;
         if (load_req) begin
            o_s_we   <= i_wb_we;
            o_s_addr <= i_wb_addr;
            o_s_data <= i_wb_data;
            o_s_sel  <= i_wb_sel;
         end
         if (load_rdata) o_wb_data <= sel_data;
         if (err_from_in)       o_wb_err_address <= i_wb_addr;
         else if (err_from_req) o_wb_err_address <= o_s_addr;
      end
   end

endmodule
